pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipeline_stage_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// Two-entry elastic pipeline register (MAIN + SKID) with flush, bubble zeroing
// and a saturating back-pressure counter; all outputs are driven from registers.
module pipeline_stage_reg #(
    parameter int DATA_W  = 16,
    parameter int NUM_OPS = 2,
    parameter int REGID_W = 4,
    parameter int CTRL_W  = 11,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0]  in_data,
    input  logic [NUM_OPS*REGID_W-1:0] in_src,
    input  logic [REGID_W-1:0]         in_dst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_OPS*DATA_W-1:0]  out_data,
    output logic [NUM_OPS*REGID_W-1:0] out_src,
    output logic [REGID_W-1:0]         out_dst,
    output logic [1:0]                 occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PW = CTRL_W + NUM_OPS*DATA_W + NUM_OPS*REGID_W + REGID_W;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PW-1:0]    in_payload;
    logic             accept;
    logic             xfer;

    assign in_payload = {in_ctrl, in_data, in_src, in_dst};

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ST_FULL;
                    end else begin
                        main_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (xfer && accept) begin
                        main_d  = in_payload;
                    end else if (xfer) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_payload;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    main_d  = '0;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q     <= ST_EMPTY;
            // NOTE: both payload entries are reset so the outputs read zero immediately after reset.
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign {out_ctrl, out_data, out_src, out_dst} = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg: the driver queues expected entries,
// a negedge monitor pops and compares on every downstream transfer.
module tb_pipeline_stage_reg;

    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 3;
    localparam int REGID_W = 4;
    localparam int CTRL_W  = 11;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [NUM_OPS*DATA_W-1:0]  data;
        logic [NUM_OPS*REGID_W-1:0] src;
        logic [REGID_W-1:0]         dst;
    } pl_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [NUM_OPS*DATA_W-1:0]  in_data;
    logic [NUM_OPS*REGID_W-1:0] in_src;
    logic [REGID_W-1:0]         in_dst;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [NUM_OPS*DATA_W-1:0]  out_data;
    logic [NUM_OPS*REGID_W-1:0] out_src;
    logic [REGID_W-1:0]         out_dst;
    logic [1:0]                 occupancy;
    logic [CNT_W-1:0]           stall_cnt;

    int  vectors = 0;
    int  errors  = 0;
    pl_t exp_q[$];

    always #5 clk = ~clk;

    pipeline_stage_reg #(
        .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .REGID_W(REGID_W),
        .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_src(in_src), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_src(out_src), .out_dst(out_dst),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every channel carries a distinct pattern so any packing error is visible.
    function automatic pl_t mk(input logic [15:0] n);
        pl_t p;
        p.ctrl = n[10:0] ^ 11'h2A5;
        p.data = {~n, 16'h1234, 16'hBEEF, n, 16'h0000, n};
        p.src  = {n[3:0] + 4'd2, n[3:0] + 4'd1, n[3:0]};
        p.dst  = ~n[3:0];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pl_t p);
        in_valid = 1'b1;
        {in_ctrl, in_data, in_src, in_dst} = p;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        {in_ctrl, in_data, in_src, in_dst} = '0;
    endtask

    task automatic check_bubble(input string name);
        check({name, "_occ"},    128'(occupancy), 128'd0);
        check({name, "_valid"},  128'(out_valid), 128'd0);
        check({name, "_ready"},  128'(in_ready),  128'd1);
        check({name, "_payload"}, 128'({out_ctrl, out_data, out_src, out_dst}), 128'd0);
    endtask

    // Monitor: downstream transfers must match the scoreboard; bubbles must be zero.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'({out_ctrl, out_data, out_src, out_dst}), 128'd0);
                end else begin
                    check("scoreboard", 128'({out_ctrl, out_data, out_src, out_dst}),
                          128'(exp_q.pop_front()));
                end
            end else if (!out_valid) begin
                check("bubble_zero", 128'({out_ctrl, out_data, out_src, out_dst}), 128'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle();
        step(); step();
        rst = 1'b0;
        check_bubble("reset");
        check("reset_stall", 128'(stall_cnt), 128'd0);

        // Streaming: one entry per cycle, visible one cycle after accept.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(mk(16'(i)));
            exp_q.push_back(mk(16'(i)));
            step();
            check("stream_occ", 128'(occupancy), 128'd1);
            check("stream_ch0", 128'(out_data[DATA_W-1:0]), 128'(i));
        end
        idle();
        step();
        check("stream_drain_occ", 128'(occupancy), 128'd0);
        check("stream_stall", 128'(stall_cnt), 128'd0);

        // Back-pressure: A into MAIN, B into SKID, then drain in order.
        out_ready = 1'b0;
        drive(mk(16'h1111)); exp_q.push_back(mk(16'h1111)); step();
        drive(mk(16'h2222)); exp_q.push_back(mk(16'h2222)); step();
        idle();
        check("bp_occ", 128'(occupancy), 128'd2);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_hold_a", 128'(out_data[DATA_W-1:0]), 128'h1111);
        check("bp_stall_1", 128'(stall_cnt), 128'd1);
        step();
        check("bp_stall_2", 128'(stall_cnt), 128'd2);
        check("bp_still_a", 128'(out_data[DATA_W-1:0]), 128'h1111);
        out_ready = 1'b1;
        step();
        check("bp_then_b", 128'(out_data[DATA_W-1:0]), 128'h2222);
        check("bp_occ_after_a", 128'(occupancy), 128'd1);
        step();
        check("bp_drained", 128'(occupancy), 128'd0);
        check("bp_stall_final", 128'(stall_cnt), 128'd2);

        // Flush in SKID while C is offered: everything dropped, stall still counts.
        out_ready = 1'b0;
        drive(mk(16'h3333)); exp_q.push_back(mk(16'h3333)); step();
        drive(mk(16'h4444)); exp_q.push_back(mk(16'h4444)); step();
        check("flush_pre_occ", 128'(occupancy), 128'd2);
        check("flush_pre_stall", 128'(stall_cnt), 128'd3);
        drive(mk(16'h5555));
        flush = 1'b1;
        step();
        exp_q.delete();
        flush = 1'b0;
        idle();
        check_bubble("flush_skid");
        check("flush_stall", 128'(stall_cnt), 128'd4);
        step(); step();
        check("flush_stays_empty", 128'(occupancy), 128'd0);

        // Flush with out_ready=1: the presented entry is delivered.
        out_ready = 1'b1;
        drive(mk(16'h6666)); exp_q.push_back(mk(16'h6666)); step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_xfer_q", 128'(exp_q.size()), 128'd0);
        check_bubble("flush_full");

        // Reset while holding two entries.
        out_ready = 1'b0;
        drive(mk(16'h7777)); exp_q.push_back(mk(16'h7777)); step();
        drive(mk(16'h8888)); exp_q.push_back(mk(16'h8888)); step();
        idle();
        check("rst_mid_pre_occ", 128'(occupancy), 128'd2);
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        check_bubble("rst_mid");
        check("rst_mid_stall", 128'(stall_cnt), 128'd0);

        // Saturation of the 4-bit stall counter.
        drive(mk(16'h9abc)); exp_q.push_back(mk(16'h9abc)); step();
        idle();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) check("sat_count_14", 128'(stall_cnt), 128'd14);
        end
        check("sat_stop", 128'(stall_cnt), 128'hF);
        check("sat_hold_data", 128'({out_ctrl, out_data, out_src, out_dst}), 128'(mk(16'h9abc)));
        out_ready = 1'b1;
        step();
        check("sat_drain_occ", 128'(occupancy), 128'd0);
        check("sat_after_drain", 128'(stall_cnt), 128'hF);

        step();
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
